// File: rtl/tiny_alu_pkg.sv
// Shared types and width constants for the tiny_alu block.
package tiny_alu_pkg;

  localparam int OPERAND_W   = 8;
  localparam int OPCODE_W    = 3;
  localparam int RESULT_W    = 16;
  localparam int MUL_LATENCY = 3;

  typedef enum logic [OPCODE_W-1:0] {
    NO_OP   = 3'b000,
    ADD_OP  = 3'b001,
    AND_OP  = 3'b010,
    XOR_OP  = 3'b011,
    MUL_OP  = 3'b100,
    SUB_OP  = 3'b101,
    UNUSED6 = 3'b110,
    UNUSED7 = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL1,
    MUL2,
    MUL3
  } state_e;

endpackage

// File: rtl/tiny_alu_if.sv
// Request/response bundle between an ALU requester (master) and tiny_alu (slave).
interface tiny_alu_if;
  import tiny_alu_pkg::*;

  logic [OPERAND_W-1:0] A;
  logic [OPERAND_W-1:0] B;
  logic [OPCODE_W-1:0]  op;
  logic                 start;
  logic                 done;
  logic [RESULT_W-1:0]  result;

  modport master (output A, output B, output op, output start, input done, input result);
  modport slave  (input A, input B, input op, input start, output done, output result);

endinterface

// File: rtl/tiny_alu_mul_pipe.sv
// Three-stage registered 8x8 multiplier; a valid bit travels alongside the data.
module tiny_alu_mul_pipe
  import tiny_alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  input  logic                 in_valid,
  output logic [RESULT_W-1:0]  product,
  output logic                 out_valid
);

  logic [OPERAND_W-1:0]   a_q;
  logic [OPERAND_W-1:0]   b_q;
  logic [RESULT_W-1:0]    prod_q;
  logic [RESULT_W-1:0]    prod_out_q;
  logic [MUL_LATENCY-1:0] valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      prod_out_q <= '0;
      valid_q    <= '0;
    end else begin
      a_q        <= a;
      b_q        <= b;
      prod_q     <= RESULT_W'(a_q) * RESULT_W'(b_q);
      prod_out_q <= prod_q;
      valid_q    <= {valid_q[MUL_LATENCY-2:0], in_valid};
    end
  end

  assign product   = prod_out_q;
  assign out_valid = valid_q[MUL_LATENCY-1];

endmodule

// File: rtl/tiny_alu.sv
// Handshake ALU: single-cycle add/and/xor, 3-cycle pipelined multiply.
// Optional subtract on op 101 is enabled by defining TINY_ALU_SUB_EN.
module tiny_alu
  import tiny_alu_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  tiny_alu_if.slave bus
);

  state_e               state;
  op_e                  req_op;
  op_e                  op_q;
  logic [OPERAND_W-1:0] a_q;
  logic [OPERAND_W-1:0] b_q;
  logic [RESULT_W-1:0]  result_q;
  logic [RESULT_W-1:0]  single_res;
  logic [RESULT_W-1:0]  mul_product;
  logic                 mul_valid;
  logic                 done_q;
  logic                 is_single;
  logic                 accept_single;
  logic                 accept_mul;

  assign req_op = op_e'(bus.op);

  always_comb begin
    is_single = 1'b0;
    case (req_op)
      ADD_OP, AND_OP, XOR_OP: is_single = 1'b1;
`ifdef TINY_ALU_SUB_EN
      SUB_OP:                 is_single = 1'b1;
`endif
      default:                is_single = 1'b0;
    endcase
  end

  // no_op and unused opcodes are simply never accepted, so the FSM stays put
  assign accept_single = (state == IDLE) && bus.start && is_single;
  assign accept_mul    = (state == IDLE) && bus.start && (req_op == MUL_OP);

  always_comb begin
    single_res = result_q;
    case (op_q)
      ADD_OP:  single_res = RESULT_W'(a_q) + RESULT_W'(b_q);
      AND_OP:  single_res = RESULT_W'(a_q & b_q);
      XOR_OP:  single_res = RESULT_W'(a_q ^ b_q);
`ifdef TINY_ALU_SUB_EN
      SUB_OP:  single_res = RESULT_W'(a_q) - RESULT_W'(b_q);
`endif
      default: single_res = result_q;
    endcase
  end

  // The pipe samples the bus operands at the accept edge itself
  tiny_alu_mul_pipe u_mul_pipe (
    .clk       (clk),
    .rst       (reset_n),
    .a         (bus.A),
    .b         (bus.B),
    .in_valid  (accept_mul),
    .product   (mul_product),
    .out_valid (mul_valid)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state    <= IDLE;
      op_q     <= NO_OP;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_single) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            op_q  <= req_op;
            state <= EXEC;
          end else if (accept_mul) begin
            op_q  <= req_op;
            state <= MUL1;
          end
        end
        EXEC: begin
          result_q <= single_res;
          done_q   <= 1'b1;
          state    <= IDLE;
        end
        MUL1: state <= MUL2;
        MUL2: state <= MUL3;
        MUL3: begin
          if (mul_valid) begin
            result_q <= mul_product;
            done_q   <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_tiny_alu.sv
// Directed self-checking bench for tiny_alu; expected values are hand-computed.
module tb_tiny_alu;

  logic clk;
  logic reset_n;
  int   assertCount;
  int   failCount;

  tiny_alu_if bus ();

  tiny_alu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op, input logic start);
    bus.A     = a;
    bus.B     = b;
    bus.op    = op;
    bus.start = start;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Accept, scramble inputs while busy, expect done+result one cycle later
  task automatic runSingle(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input logic [15:0] expected);
    applyStimulus(a, b, op, 1'b1);
    tick();
    checkOutput({tag, "_busy_done"}, {15'b0, bus.done}, 16'h0000);
    applyStimulus(8'h55, 8'hAA, op, 1'b1);
    tick();
    checkOutput({tag, "_done"}, {15'b0, bus.done}, 16'h0001);
    checkOutput({tag, "_result"}, bus.result, expected);
    applyStimulus(8'h00, 8'h00, 3'b000, 1'b0);
    tick();
    checkOutput({tag, "_done_drop"}, {15'b0, bus.done}, 16'h0000);
    checkOutput({tag, "_result_hold"}, bus.result, expected);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset_n     = 1'b1;
    applyStimulus(8'h00, 8'h00, 3'b000, 1'b0);
    tick();
    tick();
    checkOutput("reset_done", {15'b0, bus.done}, 16'h0000);
    checkOutput("reset_result", bus.result, 16'h0000);
    reset_n = 1'b0;
    tick();

    runSingle("add", 8'hFF, 8'h01, 3'b001, 16'h0100);
    runSingle("and", 8'hF0, 8'h3C, 3'b010, 16'h0030);
    runSingle("xor", 8'hF0, 8'h3C, 3'b011, 16'h00CC);

    // mul: start held, operands changed while busy
    applyStimulus(8'hFF, 8'hFF, 3'b100, 1'b1);
    tick();
    applyStimulus(8'h02, 8'h03, 3'b100, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("mul_wait%0d", i), {15'b0, bus.done}, 16'h0000);
      tick();
    end
    checkOutput("mul_wait2", {15'b0, bus.done}, 16'h0000);
    checkOutput("mul_result_hold", bus.result, 16'h00CC);
    tick();
    checkOutput("mul_done", {15'b0, bus.done}, 16'h0001);
    checkOutput("mul_result", bus.result, 16'hFE01);
    applyStimulus(8'h00, 8'h00, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("mul_after%0d", i), {15'b0, bus.done}, 16'h0000);
    end
    checkOutput("mul_result_kept", bus.result, 16'hFE01);

    // back-to-back adds: done every second cycle
    applyStimulus(8'h01, 8'h02, 3'b001, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("b2b_done%0d", i), {15'b0, bus.done}, 16'(i % 2));
      if (i % 2 == 1) checkOutput($sformatf("b2b_result%0d", i), bus.result, 16'h0003);
    end
    applyStimulus(8'h00, 8'h00, 3'b000, 1'b0);
    tick();

    // no_op and an unused opcode: nothing happens
    applyStimulus(8'h09, 8'h09, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("noop_done%0d", i), {15'b0, bus.done}, 16'h0000);
    end
    checkOutput("noop_result", bus.result, 16'h0003);
    applyStimulus(8'h09, 8'h09, 3'b110, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("op6_done%0d", i), {15'b0, bus.done}, 16'h0000);
    end
    checkOutput("op6_result", bus.result, 16'h0003);
    applyStimulus(8'h00, 8'h00, 3'b000, 1'b0);
    tick();

`ifdef TINY_ALU_SUB_EN
    runSingle("sub", 8'h03, 8'h05, 3'b101, 16'hFFFE);
`else
    applyStimulus(8'h03, 8'h05, 3'b101, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("sub_off_done%0d", i), {15'b0, bus.done}, 16'h0000);
    end
    checkOutput("sub_off_result", bus.result, 16'h0003);
    applyStimulus(8'h00, 8'h00, 3'b000, 1'b0);
    tick();
`endif

    // reset while the multiply sits in MUL2 aborts it silently
    applyStimulus(8'hFF, 8'hFF, 3'b100, 1'b1);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    checkOutput("abort_result", bus.result, 16'h0000);
    checkOutput("abort_done", {15'b0, bus.done}, 16'h0000);
    applyStimulus(8'h00, 8'h00, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("abort_hold%0d", i), {15'b0, bus.done}, 16'h0000);
    end
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("abort_quiet%0d", i), {15'b0, bus.done}, 16'h0000);
    end
    checkOutput("abort_result_zero", bus.result, 16'h0000);
    runSingle("post_reset_add", 8'h02, 8'h03, 3'b001, 16'h0005);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
